// File: rtl/sipo_rx.sv
// sipo_rx: serial-in / parallel-out receiver with a holding register and a
// valid/ready handshake towards the consumer.
// A word completes after FRAME_BITS sampled bits. It is then either written
// to the holding register, or dropped with an overrun pulse when the holding
// register is still occupied and not being consumed.
// Optional feature macro: SIPO_RX_PARITY_EN. When it is defined, each frame
// carries one extra trailing even-parity bit. That bit is checked and is not
// stored. When the macro is undefined, parity_err is tied low.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             flush,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_RX_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(WIDTH);

`ifdef SIPO_RX_PARITY_EN
    // The error flag is high when the data bits and the parity bit together
    // hold an odd number of ones.
    function automatic logic f_parity_err(input logic [WIDTH-1:0] data,
                                          input logic             par_bit);
        return (^data) ^ par_bit;
    endfunction
`endif

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_load;
    logic             w_drop;
    logic             w_valid_next;

    // Frame boundary and handshake decisions for this edge.
    always_comb begin
        w_done = shift_en & ~flush & (r_cnt == LAST_CNT);
        w_load = w_done & (~r_valid | out_ready);
        w_drop = w_done & r_valid & ~out_ready;
    end

    // Shift direction: MSB-first fills from bit 0 upward, so the first bit
    // ends up in the top position; LSB-first fills from the top downward.
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_shifted = {r_shift[WIDTH-2:0], serial_in};
        end else begin
            w_shifted = {serial_in, r_shift[WIDTH-1:1]};
        end
    end

    // Next shift-register and bit-counter state. Flush wins over shift_en.
    // Only data-bit positions shift, so a trailing parity bit leaves the
    // assembled data intact.
    always_comb begin
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        if (flush) begin
            w_shift_next = {WIDTH{1'b0}};
            w_cnt_next   = {CNT_W{1'b0}};
        end else if (shift_en) begin
            if (r_cnt < DATA_CNT) begin
                w_shift_next = w_shifted;
            end else begin
                w_shift_next = r_shift;
            end
            if (r_cnt == LAST_CNT) begin
                w_cnt_next = {CNT_W{1'b0}};
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end else begin
            w_shift_next = r_shift;
            w_cnt_next   = r_cnt;
        end
    end

    // Word presented on completion: without parity the final bit is data and
    // must be included; with parity the data is already complete in r_shift.
    always_comb begin
`ifdef SIPO_RX_PARITY_EN
        w_word = r_shift;
`else
        w_word = w_shifted;
`endif
    end

    // out_valid next state: a load sets it, a drop keeps it, and a consume
    // without a completing frame clears it.
    always_comb begin
        if (w_load) begin
            w_valid_next = 1'b1;
        end else if (w_drop) begin
            w_valid_next = r_valid;
        end else if (r_valid && out_ready) begin
            w_valid_next = 1'b0;
        end else begin
            w_valid_next = r_valid;
        end
    end

    // Shift state, holding register, handshake and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_shift   <= {WIDTH{1'b0}};
            r_out     <= {WIDTH{1'b0}};
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_valid   <= w_valid_next;
            r_busy    <= (w_cnt_next != {CNT_W{1'b0}});
            r_overrun <= w_drop;
            if (w_load) begin
                r_out <= w_word;
            end else begin
                r_out <= r_out;
            end
        end
    end

`ifdef SIPO_RX_PARITY_EN
    logic r_parity_err;

    // The parity status is loaded together with the word it describes and is
    // left alone when a word is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else if (w_load) begin
            r_parity_err <= f_parity_err(r_shift, serial_in);
        end else begin
            r_parity_err <= r_parity_err;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign parallel_out = r_out;
    assign out_valid    = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_sipo_rx.sv
// Testbench for sipo_rx. Two instances share one set of inputs: one is
// built MSB-first and the other LSB-first. A table of frames drives the
// handshake and overrun scenarios. Hand-written sequences then cover gapped
// input, consumption, reset abort and flush abort. The same bench works with
// and without SIPO_RX_PARITY_EN; with the macro defined, each frame also
// carries its table parity bit.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       shift_en;
    logic       flush;
    logic       out_ready;

    logic [3:0] m_out, l_out;
    logic       m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr, m_perr, l_perr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
        .flush(flush), .parallel_out(m_out), .out_valid(m_valid),
        .out_ready(out_ready), .busy(m_busy), .overrun(m_ovr),
        .parity_err(m_perr)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_en(shift_en),
        .flush(flush), .parallel_out(l_out), .out_valid(l_valid),
        .out_ready(out_ready), .busy(l_busy), .overrun(l_ovr),
        .parity_err(l_perr)
    );

    typedef struct {
        logic [3:0] word;      // serial stream, word[3] sent first
        logic       par;       // parity bit (used only with parity enabled)
        logic       rdy;       // out_ready on the completing edge
        logic [3:0] exp_msb;
        logic [3:0] exp_lsb;
        logic       exp_valid;
        logic       exp_ovr;
        logic       exp_perr;  // expectation with parity enabled
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] e_msb,
                             input logic [3:0] e_lsb, input logic e_valid,
                             input logic e_busy, input logic e_ovr,
                             input logic e_perr_par);
        logic e_perr;
`ifdef SIPO_RX_PARITY_EN
        e_perr = e_perr_par;
`else
        e_perr = 1'b0;
`endif
        chk({name, "_out_msb"}, 32'(m_out), 32'(e_msb));
        chk({name, "_out_lsb"}, 32'(l_out), 32'(e_lsb));
        chk({name, "_valid_msb"}, 32'(m_valid), 32'(e_valid));
        chk({name, "_valid_lsb"}, 32'(l_valid), 32'(e_valid));
        chk({name, "_busy_msb"}, 32'(m_busy), 32'(e_busy));
        chk({name, "_busy_lsb"}, 32'(l_busy), 32'(e_busy));
        chk({name, "_ovr_msb"}, 32'(m_ovr), 32'(e_ovr));
        chk({name, "_ovr_lsb"}, 32'(l_ovr), 32'(e_ovr));
        chk({name, "_perr_msb"}, 32'(m_perr), 32'(e_perr));
        chk({name, "_perr_lsb"}, 32'(l_perr), 32'(e_perr));
    endtask

    // Sends one bit. out_ready is asserted only on the given edge.
    task automatic send_bit(input logic b, input logic rdy);
        serial_in = b;
        shift_en  = 1'b1;
        out_ready = rdy;
        tick();
        shift_en  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Sends a full frame with `gap` idle cycles after every bit except the
    // final one. out_ready is driven only on the completing edge.
    task automatic send_frame(input logic [3:0] word, input logic par,
                              input logic rdy, input int gap);
        for (int i = 3; i >= 0; i--) begin
`ifdef SIPO_RX_PARITY_EN
            send_bit(word[i], 1'b0);
            repeat (gap) tick();
`else
            send_bit(word[i], (i == 0) ? rdy : 1'b0);
            if (i != 0) repeat (gap) tick();
`endif
        end
`ifdef SIPO_RX_PARITY_EN
        send_bit(par, rdy);
`endif
    endtask

    initial begin
        //            word     par   rdy   msb      lsb      vld   ovr   perr
        vecs[0] = '{4'b1011, 1'b1, 1'b0, 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{4'b0110, 1'b0, 1'b0, 4'b1011, 4'b1101, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{4'b0110, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{4'b0011, 1'b0, 1'b0, 4'b0110, 4'b0110, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{4'b1111, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0};

        // Reset held while other inputs are active: reset must win.
        rst       = 1'b0;
        serial_in = 1'b1;
        shift_en  = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst       = 1'b1;
        shift_en  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Table-driven frames: load, overrun, and simultaneous consume+load.
        foreach (vecs[k]) begin
            send_frame(vecs[k].word, vecs[k].par, vecs[k].rdy, 0);
            check_all($sformatf("vec%0d", k), vecs[k].exp_msb, vecs[k].exp_lsb,
                      vecs[k].exp_valid, 1'b0, vecs[k].exp_ovr,
                      vecs[k].exp_perr);
            tick();
            chk($sformatf("vec%0d_ovr_clear", k), 32'(m_ovr | l_ovr), 32'd0);
        end

        // Consume without a completing frame: valid drops, word kept.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_all("consume", 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

        // Gapped input: nothing is presented before the last sampled bit.
        send_bit(1'b1, 1'b0);
        repeat (2) tick();
        send_bit(1'b0, 1'b0);
        repeat (2) tick();
        send_bit(1'b1, 1'b0);
        repeat (2) tick();
        check_all("gap_mid", 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SIPO_RX_PARITY_EN
        send_bit(1'b1, 1'b0);
        repeat (2) tick();
        check_all("gap_data_done", 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
`else
        send_bit(1'b1, 1'b0);
`endif
        check_all("gap_done", 4'b1011, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame discards it.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_all("rst_abort", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'b1100, 1'b0, 1'b0, 0);
        check_all("after_rst", 4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush with shift_en: bit dropped, holding register untouched.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        flush = 1'b1;
        send_bit(1'b1, 1'b0);
        flush = 1'b0;
        check_all("flush", 4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_frame(4'b1010, 1'b0, 1'b0, 0);
        check_all("after_flush", 4'b1010, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
